// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StRmwRd,
    StRmwWr,
    StResp,
    StErr
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    extract = {{24{b[7]}}, b};
      F3_BU:   extract = {24'b0, b};
      F3_H:    extract = {{16{h[15]}}, h};
      F3_HU:   extract = {16'b0, h};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (f3)
      F3_B: r[{off, 3'b000} +: 8] = wd[7:0];
      F3_H: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    merge = r;
  endfunction

  assign load_data_o  = extract(funct3_i, offset_i, rdata_i);
  assign merge_data_o = merge(funct3_i, offset_i, old_word_i, wdata_i);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only data memory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_load_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [31:0] store_data_q;
  logic [31:0] old_word_q;
  logic [31:0] load_data_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;

  logic [31:0] align_load;
  logic [31:0] align_merge;
  logic        misalign;
  logic        out_of_range;
  logic        bad_funct3;
  logic        fault;

  lsu_align u_align (
    .funct3_i    (funct3_q),
    .offset_i    (addr_q[1:0]),
    .rdata_i     (mem_read_data),
    .old_word_i  (old_word_q),
    .wdata_i     (store_data_q),
    .load_data_o (align_load),
    .merge_data_o(align_merge)
  );

  // Fault decode works on the live request so it can steer the accept transition.
  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    out_of_range = ({2'b00, req_addr[31:2]} >= MEM_SIZE);
    if (req_is_store) begin
      bad_funct3 = req_funct3[2] | (req_funct3 == 3'b011);
    end else begin
      bad_funct3 = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end
    fault = misalign | out_of_range | bad_funct3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      store_data_q <= '0;
      old_word_q   <= '0;
      load_data_q  <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q       <= req_addr;
            funct3_q     <= req_funct3;
            is_store_q   <= req_is_store;
            store_data_q <= req_store_data;
            load_data_q  <= '0;
            req_ready_q  <= 1'b0;
            if (fault) begin
              state_q      <= StErr;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_is_store) begin
              state_q <= StLoad;
            end else if (req_funct3 == F3_W) begin
              state_q <= StWrite;
            end else begin
              state_q <= StRmwRd;
            end
          end
        end
        StLoad: begin
          load_data_q  <= align_load;
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
        end
        StWrite: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
        end
        StRmwRd: begin
          old_word_q <= mem_read_data;
          state_q    <= StRmwWr;
        end
        StRmwWr: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
        end
        StResp, StErr: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Strobes are gated by rst so a reset landing in a write state never commits.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state_q)
      StLoad, StRmwRd: begin
        mem_read = ~rst;
        mem_addr = {addr_q[31:2], 2'b00};
      end
      StWrite: begin
        mem_write      = ~rst;
        mem_addr       = {addr_q[31:2], 2'b00};
        mem_write_data = store_data_q;
      end
      StRmwWr: begin
        mem_write      = ~rst;
        mem_addr       = {addr_q[31:2], 2'b00};
        mem_write_data = align_merge;
      end
      default: ;
    endcase
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory attached.
module tb_load_store_unit;

  localparam int MS = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_load_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          writes_seen = 0;
  int          accepts = 0;
  logic [31:0] mem [MS];

  load_store_unit #(.MEM_SIZE(MS)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_store_data(req_store_data),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_load_data(resp_load_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_write_data;
      writes_seen <= writes_seen + 1;
    end
    if (req_valid && req_ready && !rst) accepts <= accepts + 1;
  end

  assign mem_read_data = mem[mem_addr[11:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a response.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && resp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=resp_valid required=none cyc=%0d", cyc);
      end else begin
        e = sbq.pop_front();
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("resp_load_data", resp_load_data, e.data);
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic e, input logic [31:0] ed,
                       input int lat);
    int   guard;
    exp_t x;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=busy required=ready");
      return;
    end
    req_valid      = 1'b1;
    req_is_store   = st;
    req_funct3     = f3;
    req_addr       = a;
    req_store_data = d;
    x.err  = e;
    x.data = ed;
    x.cyc  = cyc + lat;
    sbq.push_back(x);
    @(negedge clk);
    // Scramble inputs after accept; the DUT must ignore them.
    req_valid      = 1'b0;
    req_is_store   = ~st;
    req_funct3     = 3'b111;
    req_addr       = 32'hFFFF_FFFF;
    req_store_data = 32'h5A5A_5A5A;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || !req_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0 || !req_ready) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=pending%0d required=pending0", sbq.size());
      sbq.delete();
    end
  endtask

  logic [31:0] hs_addr [9];
  int          acc0;
  int          wr0;
  int          k;
  exp_t        hx;

  initial begin
    for (int i = 0; i < MS; i++) mem[i] = '0;
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_is_store   = 1'b0;
    req_funct3     = 3'b000;
    req_addr       = '0;
    req_store_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_load_data", resp_load_data, 32'd0);
    check("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // Word store then load.
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
    wait_idle();
    check("sw_mem4", mem[4], 32'hDEAD_BEEF);

    // Extension cases.
    mem[4] = 32'h80FF_7F01;
    issue(1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 32'hFFFF_FFFF, 2);
    issue(1'b0, 3'b100, 32'h12, 32'h0, 1'b0, 32'h0000_00FF, 2);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_80FF, 2);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000_7F01, 2);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 2);
    issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'h0000_007F, 2);
    issue(1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'h0000_7F01, 2);
    wait_idle();

    // Sub-word read-modify-write; upper store-data bits must be ignored.
    mem[5] = 32'h1122_3344;
    issue(1'b1, 3'b000, 32'h15, 32'hFFFF_FFAA, 1'b0, 32'h0, 3);
    wait_idle();
    check("sb_mem5", mem[5], 32'h1122_AA44);
    issue(1'b1, 3'b001, 32'h16, 32'h1234_BEEF, 1'b0, 32'h0, 3);
    wait_idle();
    check("sh_mem5", mem[5], 32'hBEEF_AA44);

    // Faults: no writes, memory untouched.
    wr0 = writes_seen;
    issue(1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b001, 32'h13, 32'hCAFE_CAFE, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b010, 32'h1000, 32'hCAFE_CAFE, 1'b1, 32'h0, 1);
    issue(1'b0, 3'b111, 32'h10, 32'h0, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b100, 32'h10, 32'hCAFE_CAFE, 1'b1, 32'h0, 1);
    wait_idle();
    check("fault_writes", writes_seen - wr0, 32'd0);
    check("fault_mem4", mem[4], 32'h80FF_7F01);
    check("fault_mem5", mem[5], 32'hBEEF_AA44);

    // Handshake: valid held high, address changes every cycle.
    for (int i = 0; i < 9; i++) begin
      mem[16 + i] = 32'hA000_0000 + i;
      hs_addr[i]  = 32'h40 + 4 * i;
    end
    @(negedge clk);
    k    = cyc;
    acc0 = accepts;
    hx.err = 1'b0;
    hx.data = 32'hA000_0000; hx.cyc = k + 2; sbq.push_back(hx);
    hx.data = 32'hA000_0003; hx.cyc = k + 5; sbq.push_back(hx);
    hx.data = 32'hA000_0006; hx.cyc = k + 8; sbq.push_back(hx);
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    for (int i = 0; i < 9; i++) begin
      req_addr = hs_addr[i];
      check($sformatf("hs_ready_%0d", i), {31'b0, req_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("hs_accepts", accepts - acc0, 32'd3);
    wait_idle();

    // Reset landing in the RMW write cycle.
    mem[5] = 32'h5566_7788;
    @(negedge clk);
    req_valid      = 1'b1;
    req_is_store   = 1'b1;
    req_funct3     = 3'b000;
    req_addr       = 32'h14;
    req_store_data = 32'h0000_0099;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rmw_wr_strobe", {31'b0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_gates_write", {31'b0, mem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_rmw_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rmw_no_resp", {31'b0, resp_valid}, 32'd0);
    check("rst_rmw_mem5", mem[5], 32'h5566_7788);

    repeat (5) @(negedge clk);
    check("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
